// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// Defines the loader FSM state type and the word size in bytes.
package loader_pkg;

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and imem-write bundle of the loader.
// master: loader side (takes rx bytes, drives imem writes); slave: peer side.
interface imem_loader_if;

   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport master (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs little-endian bytes into 32-bit words.
// Ports: clk, rst, clear, byte_hs, rx_data in; word, word_valid out.
module byte_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_hs,
   input  logic [7:0]  rx_data,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam int CW = $clog2(BYTES_PER_WORD);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0]   sr_q, sr_d;

   // Bytes enter at the top and shift down, so after three
   // bytes sr holds {b2,b1,b0}; the fourth byte lands in [31:24].
   assign word       = {rx_data, sr_q};
   assign word_valid = byte_hs &&
                       (cnt_q == CW'(BYTES_PER_WORD - 1));

   always_comb begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
      if (clear) begin
         cnt_d = '0;
         sr_d  = '0;
      end else if (byte_hs) begin
         cnt_d = cnt_q + CW'(1);
         sr_d  = {rx_data, sr_q[23:8]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         sr_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sr_q  <= sr_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a LEN-prefixed program byte stream into imem; holds the core
// in reset until done. Ports: clk, rst, bus (imem_loader_if.master),
// load_req, core_rst, done, error. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic           clk,
   input  logic           rst,
   imem_loader_if.master  bus,
   input  logic           load_req,
   output logic           core_rst,
   output logic           done,
   output logic           error
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int IW    = ADDR_WIDTH + 1;

   loader_state_t state_q, state_d;
   logic [IW-1:0] word_idx_q, word_idx_d;
   logic [IW-1:0] n_q, n_d;
   logic          rx_ready_q, rx_ready_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          core_rst_q, core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]   csum_q, csum_d;
`endif

   logic          byte_hs;
   logic          clear;
   logic [31:0]   word;
   logic          word_valid;

   assign byte_hs = bus.rx_valid && rx_ready_q;

   byte_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .byte_hs    (byte_hs),
      .rx_data    (bus.rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      n_d        = n_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      clear      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      unique case (state_q)
         S_LEN: begin
            if (word_valid) begin
               if (word > 32'(DEPTH)) begin
                  state_d = S_ERR;
               end else if (word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_d  = '0;
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  n_d        = word[IW-1:0];
                  word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_d     = '0;
`endif
                  state_d    = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (word_valid) begin
               we_d       = 1'b1;
               addr_d     = 32'(word_idx_q) << 2;
               wdata_d    = word;
               word_idx_d = word_idx_q + IW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = csum_q + word;
`endif
               // Leave on the last word so the FSM state
               // changes on the same edge as its write strobe.
               if (word_idx_q == n_q - IW'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (word_valid) begin
               state_d = (word == csum_q) ? S_DONE : S_ERR;
            end
         end
`endif
         S_DONE, S_ERR: begin
            if (load_req) begin
               state_d    = S_LEN;
               clear      = 1'b1;
               word_idx_d = '0;
               n_d        = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end
         default: state_d = S_LEN;
      endcase

      rx_ready_d = (state_d == S_LEN) ||
                   (state_d == S_DATA) ||
                   (state_d == S_CSUM);
      // Release one cycle after entering DONE; reassert on the
      // same edge that leaves DONE.
      core_rst_d = (state_d != S_DONE) ||
                   (state_q != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LEN;
         word_idx_q <= '0;
         n_q        <= '0;
         rx_ready_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         core_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         n_q        <= n_d;
         rx_ready_q <= rx_ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         core_rst_q <= core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.rx_ready   = rx_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign core_rst       = core_rst_q;
   assign done           = (state_q == S_DONE);
   assign error          = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random program frames, expected imem
// writes derived from the word list (word i -> byte address 4*i).
module tb_imem_loader;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   logic load_req;
   logic core_rst;
   logic done;
   logic error;

   imem_loader_if bus ();

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .load_req (load_req),
      .core_rst (core_rst),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int crst_fall = -1;
   logic crst_prev = 1'b1;

   int          hs_cyc[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   logic [31:0] words[$];

   // Observe the bus mid-cycle, away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (bus.rx_valid && bus.rx_ready) hs_cyc.push_back(cyc);
      if (bus.imem_we) begin
         wr_addr.push_back(bus.imem_addr);
         wr_data.push_back(bus.imem_wdata);
         wr_cyc.push_back(cyc);
      end
      if (crst_prev && !core_rst) crst_fall = cyc;
      crst_prev = core_rst;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      hs_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      crst_fall = -1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      load_req = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      tick(3);
      rst = 1'b0;
      clear_log();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) begin
         bus.rx_valid = 1'b0;
         bus.rx_data = 8'($urandom);
         tick();
      end
      bus.rx_valid = 1'b1;
      bus.rx_data = b;
      t = 0;
      while (!bus.rx_ready && t < 64) begin
         tick();
         t++;
      end
      if (t == 64) begin
         vectors++;
         miscompares++;
         $display("FAIL send_byte timeout: rx_ready=%0b required 1",
                  bus.rx_ready);
      end else begin
         tick();
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int k = 0; k < 4; k++) begin
         send_byte(w[8*k +: 8],
                   maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
      end
   endtask

   function automatic logic [31:0] model_csum();
      logic [31:0] s = '0;
      foreach (words[i]) s += words[i];
      return s;
   endfunction

   task automatic send_frame(input int maxgap);
      send_word(32'(words.size()), maxgap);
      foreach (words[i]) send_word(words[i], maxgap);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(model_csum(), maxgap);
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load_req = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      tick(3);
      vectors++;
      if ({bus.rx_ready, bus.imem_we, core_rst, done, error}
          !== 5'b00100) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b required 00100",
                  {bus.rx_ready, bus.imem_we, core_rst, done, error});
      end
      vectors++;
      if ({bus.imem_addr, bus.imem_wdata} !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_bus: addr=%h wdata=%h required 0",
                  bus.imem_addr, bus.imem_wdata);
      end
      rst = 1'b0;
      vectors++;
      if (bus.rx_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_early: got %b required 0", bus.rx_ready);
      end
      tick();
      vectors++;
      if (bus.rx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_rise: got %b required 1", bus.rx_ready);
      end
      clear_log();
   endtask

   task automatic test_basic();
      apply_reset();
      words = '{32'h00500093, 32'h00000113};
      send_frame(0);
      tick(3);
      vectors++;
      if (wr_addr.size() !== 2) begin
         miscompares++;
         $display("FAIL basic_count: got %0d required 2", wr_addr.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== words[i]) begin
               miscompares++;
               $display("FAIL basic_wr%0d: got %h/%h required %h/%h", i,
                        wr_addr[i], wr_data[i], 32'(4 * i), words[i]);
            end
            vectors++;
            if (wr_cyc[i] !== hs_cyc[4 * i + 7] + 1) begin
               miscompares++;
               $display("FAIL basic_lat%0d: got %0d required %0d", i,
                        wr_cyc[i], hs_cyc[4 * i + 7] + 1);
            end
         end
         vectors++;
         if (crst_fall !== wr_cyc[1] + 1) begin
            miscompares++;
            $display("FAIL basic_crst: fell %0d required %0d",
                     crst_fall, wr_cyc[1] + 1);
         end
      end
      vectors++;
      if ({done, error, core_rst, bus.rx_ready} !== 4'b1000) begin
         miscompares++;
         $display("FAIL basic_done: got %b required 1000",
                  {done, error, core_rst, bus.rx_ready});
      end
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      vectors++;
      if ({done, core_rst, bus.rx_ready} !== 3'b011) begin
         miscompares++;
         $display("FAIL reload: got %b required 011",
                  {done, core_rst, bus.rx_ready});
      end
   endtask

   task automatic test_empty();
      apply_reset();
      words.delete();
      send_frame(0);
      vectors++;
      if ({done, core_rst} !== 2'b11) begin
         miscompares++;
         $display("FAIL empty_done: got %b required 11", {done, core_rst});
      end
      tick();
      vectors++;
      if ({done, error, core_rst} !== 3'b100 || wr_addr.size() != 0) begin
         miscompares++;
         $display("FAIL empty_end: got %b writes=%0d required 100/0",
                  {done, error, core_rst}, wr_addr.size());
      end
   endtask

   task automatic test_overflow();
      int bad;
      apply_reset();
      send_word(32'(DEPTH + 1), 0);
      tick();
      vectors++;
      if ({error, done, core_rst, bus.rx_ready} !== 4'b1010) begin
         miscompares++;
         $display("FAIL ovf_err: got %b required 1010",
                  {error, done, core_rst, bus.rx_ready});
      end
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'h5A;
      tick(5);
      bus.rx_valid = 1'b0;
      vectors++;
      if (hs_cyc.size() !== 4 || wr_addr.size() !== 0 || core_rst !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_hold: hs=%0d wr=%0d crst=%b required 4/0/1",
                  hs_cyc.size(), wr_addr.size(), core_rst);
      end
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      vectors++;
      if ({error, core_rst} !== 2'b01) begin
         miscompares++;
         $display("FAIL ovf_reload: got %b required 01", {error, core_rst});
      end
      clear_log();
      words.delete();
      for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
      send_frame(0);
      tick(3);
      vectors++;
      if (wr_addr.size() !== DEPTH) begin
         miscompares++;
         $display("FAIL full_count: got %0d required %0d",
                  wr_addr.size(), DEPTH);
      end else begin
         bad = 0;
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== words[i]) bad++;
         end
         vectors++;
         if (bad != 0) begin
            miscompares++;
            $display("FAIL full_data: %0d bad writes required 0", bad);
         end
         vectors++;
         if (wr_addr[DEPTH - 1] !== 32'hFFC) begin
            miscompares++;
            $display("FAIL full_last: got %h required ffc",
                     wr_addr[DEPTH - 1]);
         end
      end
      vectors++;
      if ({done, error, core_rst} !== 3'b100) begin
         miscompares++;
         $display("FAIL full_done: got %b required 100",
                   {done, error, core_rst});
      end
   endtask

   task automatic test_gaps();
      apply_reset();
      words.delete();
      for (int i = 0; i < 3; i++) words.push_back($urandom);
      send_word(32'd3, 3);
      // A restart request mid-frame must be ignored.
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      foreach (words[i]) send_word(words[i], 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(model_csum(), 3);
`endif
      tick(3);
      vectors++;
      if (wr_addr.size() !== 3) begin
         miscompares++;
         $display("FAIL gap_count: got %0d required 3", wr_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== words[i]) begin
               miscompares++;
               $display("FAIL gap_wr%0d: got %h/%h required %h/%h", i,
                        wr_addr[i], wr_data[i], 32'(4 * i), words[i]);
            end
            vectors++;
            if (wr_cyc[i] !== hs_cyc[4 * i + 7] + 1) begin
               miscompares++;
               $display("FAIL gap_lat%0d: got %0d required %0d", i,
                        wr_cyc[i], hs_cyc[4 * i + 7] + 1);
            end
         end
      end
      vectors++;
      if ({done, error, core_rst} !== 3'b100) begin
         miscompares++;
         $display("FAIL gap_done: got %b required 100",
                  {done, error, core_rst});
      end
   endtask

   task automatic test_midreset();
      apply_reset();
      send_word(32'd1, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      apply_reset();
      words = '{32'($urandom)};
      send_frame(1);
      tick(3);
      vectors++;
      if (wr_addr.size() !== 1) begin
         miscompares++;
         $display("FAIL rst_count: got %0d required 1", wr_addr.size());
      end else begin
         vectors++;
         if (wr_addr[0] !== 32'h0 || wr_data[0] !== words[0]) begin
            miscompares++;
            $display("FAIL rst_wr: got %h/%h required 0/%h",
                     wr_addr[0], wr_data[0], words[0]);
         end
      end
      vectors++;
      if ({done, error} !== 2'b10) begin
         miscompares++;
         $display("FAIL rst_done: got %b required 10", {done, error});
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      apply_reset();
      words = '{32'd1, 32'd2};
      send_word(32'd2, 0);
      send_word(32'd1, 0);
      send_word(32'd2, 0);
      send_word(32'd3, 0);
      tick(2);
      vectors++;
      if ({done, error, core_rst} !== 3'b100 || wr_addr.size() !== 2) begin
         miscompares++;
         $display("FAIL csum_ok: got %b wr=%0d required 100/2",
                  {done, error, core_rst}, wr_addr.size());
      end
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      clear_log();
      send_word(32'd2, 0);
      send_word(32'd1, 0);
      send_word(32'd2, 0);
      send_word(32'd4, 0);
      tick(2);
      vectors++;
      if ({done, error, core_rst, bus.rx_ready} !== 4'b0110) begin
         miscompares++;
         $display("FAIL csum_bad: got %b required 0110",
                  {done, error, core_rst, bus.rx_ready});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_overflow();
      test_gaps();
      test_midreset();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
